// File: rtl/dmem_lsu_if.sv
// ============================================================================
//  Module      : dmem_lsu_if
//  Description : Memory-stage bus and TX peripheral signals for dmem_lsu.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dmem_lsu_if;
    logic        MemWriteM;
    logic [2:0]  funct3M;
    logic [31:0] Mem_WrAddr;
    logic [31:0] Mem_WrData;
    logic [31:0] ReadDataM;
    logic [7:0]  io_data;
    logic        io_valid;
    logic        io_ready;
    logic [7:0]  ovf_cnt;
    logic        misalign;

    modport master (
        output MemWriteM, funct3M, Mem_WrAddr, Mem_WrData, io_ready,
        input  ReadDataM, io_data, io_valid, ovf_cnt, misalign
    );

    modport slave (
        input  MemWriteM, funct3M, Mem_WrAddr, Mem_WrData, io_ready,
        output ReadDataM, io_data, io_valid, ovf_cnt, misalign
    );
endinterface

`default_nettype wire

// File: rtl/dmem_lsu.sv
// ============================================================================
//  Module      : dmem_lsu
//  Description : RV32I memory-stage load/store unit: data RAM plus TX FIFO MMIO.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_lsu #(
    parameter int          DEPTH_WORDS = 64,
    parameter logic [31:0] MMIO_TX     = 32'h0000_1000,
    parameter logic [31:0] MMIO_STAT   = 32'h0000_1004
) (
    input  wire logic    clk,
    input  wire logic    reset,
    dmem_lsu_if.slave    bus
);

    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [31:0] RAM_BYTES = 32'(4 * DEPTH_WORDS);

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    logic [31:0] mem [DEPTH_WORDS];

    logic [31:0] addr;
    logic [2:0]  f3;
    logic        in_ram;
    logic [AW-1:0] idx;

    assign addr   = bus.Mem_WrAddr;
    assign f3     = bus.funct3M;
    assign in_ram = (addr < RAM_BYTES);
    assign idx    = addr[AW+1:2];

    // ------------------------------------------------------------------
    // Store decode: lane enables, replicated data, alignment check
    // ------------------------------------------------------------------
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        mis_st;

    always_comb begin
        be     = 4'b0000;
        wdata  = bus.Mem_WrData;
        mis_st = 1'b0;
        case (f3)
            F3_B: begin
                be    = 4'b0001 << addr[1:0];
                wdata = {4{bus.Mem_WrData[7:0]}};
            end
            F3_H: begin
                be     = addr[1] ? 4'b1100 : 4'b0011;
                wdata  = {2{bus.Mem_WrData[15:0]}};
                mis_st = addr[0];
            end
            F3_W: begin
                be     = 4'b1111;
                mis_st = (addr[1:0] != 2'b00);
            end
            default: be = 4'b0000;
        endcase
    end

    logic st_ram;
    logic st_mis;
    assign st_ram = bus.MemWriteM && in_ram && !mis_st;
    assign st_mis = bus.MemWriteM && in_ram && mis_st;

    // RAM is deliberately not cleared by reset; only the write is gated
    always_ff @(posedge clk) begin
        if (!reset && st_ram) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset)       bus.misalign <= 1'b0;
        else if (st_mis) bus.misalign <= 1'b1;
    end

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    logic [7:0] fifo [4];
    logic [1:0] rd_ptr;
    logic [1:0] wr_ptr;
    logic [2:0] count;
    logic       empty;
    logic       full;
    logic       push_req;
    logic       pop;
    logic       push_ok;
    logic       drop;

    assign empty    = (count == 3'd0);
    assign full     = (count == 3'd4);
    assign push_req = bus.MemWriteM && (addr == MMIO_TX);
    assign pop      = !empty && bus.io_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle
    assign push_ok  = push_req && (!full || pop);
    assign drop     = push_req && full && !pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr      <= 2'd0;
            wr_ptr      <= 2'd0;
            count       <= 3'd0;
            bus.ovf_cnt <= 8'd0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 2'd1;
            if (pop)     rd_ptr <= rd_ptr + 2'd1;
            case ({push_ok, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
            if (drop && bus.ovf_cnt != 8'hFF) bus.ovf_cnt <= bus.ovf_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push_ok) fifo[wr_ptr] <= bus.Mem_WrData[7:0];
    end

    assign bus.io_valid = !empty;
    assign bus.io_data  = empty ? 8'h00 : fifo[rd_ptr];

    // ------------------------------------------------------------------
    // Combinational load path
    // ------------------------------------------------------------------
    logic [31:0] word;
    logic [7:0]  bsel;
    logic [15:0] hsel;

    assign word = in_ram ? mem[idx] : 32'h0;
    assign bsel = word[8*addr[1:0] +: 8];
    assign hsel = addr[1] ? word[31:16] : word[15:0];

    always_comb begin
        bus.ReadDataM = 32'h0;
        if (addr == MMIO_STAT) begin
            bus.ReadDataM = {29'b0, (bus.ovf_cnt != 8'd0), full, empty};
        end else if (in_ram) begin
            case (f3)
                F3_B:  bus.ReadDataM = {{24{bsel[7]}}, bsel};
                F3_BU: bus.ReadDataM = {24'b0, bsel};
                F3_H:  bus.ReadDataM = addr[0] ? 32'h0 : {{16{hsel[15]}}, hsel};
                F3_HU: bus.ReadDataM = addr[0] ? 32'h0 : {16'b0, hsel};
                F3_W:  bus.ReadDataM = (addr[1:0] != 2'b00) ? 32'h0 : word;
                default: bus.ReadDataM = 32'h0;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dmem_lsu.sv
// ============================================================================
//  Module      : tb_dmem_lsu
//  Description : Directed self-checking bench for dmem_lsu.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_lsu;

    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    dmem_lsu_if bus ();

    dmem_lsu dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1; applies a store for exactly one clock edge
    task automatic store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        bus.MemWriteM  = 1'b1;
        bus.funct3M    = f3;
        bus.Mem_WrAddr = a;
        bus.Mem_WrData = d;
        @(posedge clk); #1;
        bus.MemWriteM  = 1'b0;
    endtask

    task automatic load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] exp);
        bus.funct3M    = f3;
        bus.Mem_WrAddr = a;
        #1;
        check(tag, bus.ReadDataM, exp);
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    initial begin
        reset          = 1'b1;
        bus.MemWriteM  = 1'b0;
        bus.funct3M    = 3'b010;
        bus.Mem_WrAddr = 32'h0;
        bus.Mem_WrData = 32'h0;
        bus.io_ready   = 1'b0;
        tick(); tick();
        reset = 1'b0;

        check("rst_valid", {31'b0, bus.io_valid}, 32'h0);
        check("rst_data", {24'b0, bus.io_data}, 32'h0);
        check("rst_ovf", {24'b0, bus.ovf_cnt}, 32'h0);
        check("rst_mis", {31'b0, bus.misalign}, 32'h0);
        load("rst_stat", 3'b010, 32'h1004, 32'h1);

        // Loads of each width and sign
        store(3'b010, 32'h10, 32'h8899AABB);
        load("lb_11", 3'b000, 32'h11, 32'hFFFFFFAA);
        load("lbu_11", 3'b100, 32'h11, 32'h000000AA);
        load("lh_12", 3'b001, 32'h12, 32'hFFFF8899);
        load("lhu_12", 3'b101, 32'h12, 32'h00008899);
        load("lw_10", 3'b010, 32'h10, 32'h8899AABB);
        load("lb_10", 3'b000, 32'h10, 32'hFFFFFFBB);
        tick();
        store(3'b000, 32'h13, 32'h0000005A);
        load("sb_13", 3'b010, 32'h10, 32'h5A99AABB);
        tick();
        store(3'b001, 32'h10, 32'hFFFF1234);
        load("sh_10", 3'b010, 32'h10, 32'h5A991234);
        load("lh_mis", 3'b001, 32'h11, 32'h0);
        load("lw_mis", 3'b010, 32'h12, 32'h0);
        load("f3_011", 3'b011, 32'h10, 32'h0);
        load("f3_110", 3'b110, 32'h10, 32'h0);
        load("ld_tx", 3'b010, 32'h1000, 32'h0);

        // Boundary: last RAM word, and first address past RAM
        tick();
        store(3'b010, 32'hFC, 32'h13579BDF);
        load("lw_fc", 3'b010, 32'hFC, 32'h13579BDF);
        tick();
        store(3'b010, 32'h00, 32'hCAFEF00D);
        tick();
        store(3'b010, 32'h100, 32'h0BADBEEF);
        load("oob_st", 3'b010, 32'h00, 32'hCAFEF00D);
        load("oob_ld", 3'b010, 32'h100, 32'h0);

        // Misaligned store suppression and sticky flag
        tick();
        store(3'b010, 32'h20, 32'h11112222);
        check("mis_pre", {31'b0, bus.misalign}, 32'h0);
        store(3'b010, 32'h22, 32'hDEADBEEF);
        check("mis_set", {31'b0, bus.misalign}, 32'h1);
        load("mis_ram", 3'b010, 32'h20, 32'h11112222);
        tick();
        store(3'b001, 32'h21, 32'hDEADBEEF);
        load("mis_sh", 3'b010, 32'h20, 32'h11112222);
        tick();
        store(3'b010, 32'h24, 32'h33334444);
        load("aln_after", 3'b010, 32'h24, 32'h33334444);
        check("mis_sticky", {31'b0, bus.misalign}, 32'h1);
        tick();
        reset = 1'b1; tick(); reset = 1'b0;
        check("mis_clr", {31'b0, bus.misalign}, 32'h0);
        load("ram_keep", 3'b010, 32'h24, 32'h33334444);

        // Five pushes with peripheral stalled: one drop
        for (int i = 1; i <= 5; i++) store(3'b000, 32'h1000, 32'(i));
        check("f_valid", {31'b0, bus.io_valid}, 32'h1);
        check("f_head", {24'b0, bus.io_data}, 32'h01);
        check("f_ovf", {24'b0, bus.ovf_cnt}, 32'h1);
        load("f_stat", 3'b010, 32'h1004, 32'h6);

        bus.io_ready = 1'b1;
        #1;
        for (int i = 1; i <= 4; i++) begin
            check("drain", {24'b0, bus.io_data}, 32'(i));
            tick();
        end
        check("drain_valid", {31'b0, bus.io_valid}, 32'h0);
        check("drain_data", {24'b0, bus.io_data}, 32'h0);
        load("drain_stat", 3'b000, 32'h1004, 32'h5);
        tick();
        check("rdy_empty", {31'b0, bus.io_valid}, 32'h0);
        bus.io_ready = 1'b0;

        // Simultaneous push and pop while full
        for (int i = 0; i < 4; i++) store(3'b010, 32'h1000, 32'h100 + 32'(8'h10 + i));
        load("full_stat", 3'b010, 32'h1004, 32'h6);
        check("pp_head", {24'b0, bus.io_data}, 32'h10);
        bus.io_ready = 1'b1;
        store(3'b000, 32'h1000, 32'h000000EE);
        load("pp_stat", 3'b010, 32'h1004, 32'h6);
        check("pp_ovf", {24'b0, bus.ovf_cnt}, 32'h1);
        check("pp_b1", {24'b0, bus.io_data}, 32'h11);
        tick();
        check("pp_b2", {24'b0, bus.io_data}, 32'h12);
        tick();
        check("pp_b3", {24'b0, bus.io_data}, 32'h13);
        tick();
        check("pp_b4", {24'b0, bus.io_data}, 32'hEE);
        tick();
        check("pp_empty", {31'b0, bus.io_valid}, 32'h0);
        bus.io_ready = 1'b0;

        // Overflow counter saturation
        for (int i = 0; i < 4; i++) store(3'b000, 32'h1000, 32'h0);
        for (int i = 0; i < 260; i++) store(3'b000, 32'h1000, 32'h0);
        check("ovf_sat", {24'b0, bus.ovf_cnt}, 32'hFF);

        // Reset with queued bytes and a concurrent push
        tick();
        reset = 1'b1; tick(); reset = 1'b0;
        store(3'b010, 32'h30, 32'h0F0F0F0F);
        for (int i = 0; i < 3; i++) store(3'b000, 32'h1000, 32'h40 + 32'(i));
        check("q3_valid", {31'b0, bus.io_valid}, 32'h1);
        reset = 1'b1;
        bus.io_ready = 1'b1;
        store(3'b000, 32'h1000, 32'h77);
        reset = 1'b0;
        bus.io_ready = 1'b0;
        check("rq_valid", {31'b0, bus.io_valid}, 32'h0);
        check("rq_ovf", {24'b0, bus.ovf_cnt}, 32'h0);
        load("rq_stat", 3'b010, 32'h1004, 32'h1);
        load("rq_ram", 3'b010, 32'h30, 32'h0F0F0F0F);
        tick();
        check("rq_stay", {31'b0, bus.io_valid}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        miscompares++;
        $display("FAIL timeout: observed no finish, required finish");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
